// File: rtl/configs_loader.sv
// configs_loader: write-side sequencer for the configuration-latch bank.
// Takes configuration words over valid/ready and, per word, drives the
// data bus followed by a one-cycle-guarded one-hot latch enable so the
// transparent latches always see stable data around their strobe.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | no load active; waits for io_start
// S_WAIT   | ready high; waits for a valid word at the current index
// S_SETUP  | new word on io_d_out, all enables low (setup margin)
// S_STROBE | enable[idx] high for STROBE_LEN cycles
// S_HOLD   | enables low, data unchanged (hold margin); advance or finish
// S_DONE   | one-cycle io_done pulse, then back to idle
module configs_loader #(
  parameter int WORD_W     = 32,
  parameter int NUM_WORDS  = 34,
  parameter int IDX_W      = 6,
  parameter int STROBE_LEN = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_abort,
  input  logic [WORD_W-1:0]    io_word_in,
  input  logic                 io_word_valid,
  output logic                 io_word_ready,
  output logic [WORD_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic [IDX_W-1:0]     io_word_idx,
  output logic                 io_busy,
  output logic                 io_done
);

  localparam int CNT_W = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]           r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [CNT_W-1:0]     r_cnt;
  logic [WORD_W-1:0]    r_d_out;
  logic [NUM_WORDS-1:0] r_en;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;

  logic [2:0]           w_state_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [NUM_WORDS-1:0] w_en_nxt;
  logic                 w_accept;

  // Ready is a registered copy of (state == S_WAIT), so this is a real handshake.
  assign w_accept = r_ready && io_word_valid;

  // Next-state, index and strobe-counter logic; abort overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    if (io_abort) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_start) begin
            w_state_nxt = S_WAIT;
            w_idx_nxt   = '0;
          end
        end
        S_WAIT: begin
          if (w_accept) w_state_nxt = S_SETUP;
        end
        S_SETUP: begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = '0;
        end
        S_STROBE: begin
          if (r_cnt == CNT_W'(STROBE_LEN - 1)) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (r_idx == IDX_W'(NUM_WORDS - 1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_WAIT;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // One-hot enable decoded from the next state so the registered output is glitch-free.
  always_comb begin
    w_en_nxt = '0;
    if (w_state_nxt == S_STROBE) w_en_nxt = NUM_WORDS'(1) << w_idx_nxt;
  end

  // State and Moore-decoded output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_en    <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= w_en_nxt;
      r_ready <= (w_state_nxt == S_WAIT);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Data register moves only on an accepted, non-aborted transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_out <= '0;
    end else if (w_accept && !io_abort) begin
      r_d_out <= io_word_in;
    end
  end

  assign io_word_ready = r_ready;
  assign io_d_out      = r_d_out;
  assign io_configs_en = r_en;
  assign io_word_idx   = r_idx;
  assign io_busy       = r_busy;
  assign io_done       = r_done;

endmodule

// File: tb/tb_configs_loader.sv
// Testbench for configs_loader: default instance plus a small
// NUM_WORDS=3 / STROBE_LEN=1 instance. Inputs are driven and outputs
// sampled on the falling edge; cycle c of a scenario is the clock period
// whose inputs are driven at the c-th falling edge of that scenario.
module tb_configs_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_start, io_abort, io_word_valid;
  logic [31:0] io_word_in;
  logic        io_word_ready, io_busy, io_done;
  logic [31:0] io_d_out;
  logic [33:0] io_configs_en;
  logic [5:0]  io_word_idx;

  logic        sw_start, sw_abort, sw_valid;
  logic [31:0] sw_word;
  logic        sw_ready, sw_busy, sw_done;
  logic [31:0] sw_d_out;
  logic [2:0]  sw_en;
  logic [1:0]  sw_idx;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  configs_loader u_dut (
    .clk(clk), .reset(reset),
    .io_start(io_start), .io_abort(io_abort),
    .io_word_in(io_word_in), .io_word_valid(io_word_valid),
    .io_word_ready(io_word_ready), .io_d_out(io_d_out),
    .io_configs_en(io_configs_en), .io_word_idx(io_word_idx),
    .io_busy(io_busy), .io_done(io_done)
  );

  configs_loader #(.WORD_W(32), .NUM_WORDS(3), .IDX_W(2), .STROBE_LEN(1)) u_sw (
    .clk(clk), .reset(reset),
    .io_start(sw_start), .io_abort(sw_abort),
    .io_word_in(sw_word), .io_word_valid(sw_valid),
    .io_word_ready(sw_ready), .io_d_out(sw_d_out),
    .io_configs_en(sw_en), .io_word_idx(sw_idx),
    .io_busy(sw_busy), .io_done(sw_done)
  );

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      io_start = 1'($urandom); io_abort = 1'($urandom);
      io_word_valid = 1'($urandom); io_word_in = $urandom;
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (io_d_out !== 0 || io_configs_en !== 0 || io_word_idx !== 0 ||
          io_word_ready !== 0 || io_busy !== 0 || io_done !== 0) begin
        fails++;
        $display("FAIL reset_outputs c=%0d got d=%h en=%h idx=%0d rdy=%b busy=%b done=%b exp all 0",
                 c, io_d_out, io_configs_en, io_word_idx, io_word_ready, io_busy, io_done);
      end
    end
    reset = 1'b0;
    io_start = 0; io_abort = 0; io_word_valid = 1'b1; io_word_in = 32'h5555AAAA;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (io_word_ready !== 1'b0 || io_busy !== 1'b0 || io_d_out !== 0) begin
        fails++;
        $display("FAIL reset_idle c=%0d got rdy=%b busy=%b d=%h exp 0 0 0",
                 c, io_word_ready, io_busy, io_d_out);
      end
    end
    io_word_valid = 0;
  endtask

  // Full load with continuous valid, optionally stalling valid for gap_len
  // cycles in front of word gap_k. Also pulses io_start at cycle 50.
  task automatic test_load(input int gap_k, input int gap_len, input string name);
    int acc[34];
    logic [33:0] e_en[256];
    logic [31:0] e_d[256];
    logic [5:0]  e_idx[256];
    bit e_rdy[256], e_bsy[256], e_dn[256], e_ic[256], e_dv[256];
    int dn, last, cur_k, pushed, st, en_end;
    logic [33:0] prev_en;
    logic [31:0] exp_w;
    bit gap;

    for (int c = 0; c < 256; c++) begin
      e_en[c] = '0; e_d[c] = '0; e_idx[c] = '0;
      e_rdy[c] = 0; e_bsy[c] = 0; e_dn[c] = 0; e_ic[c] = 0; e_dv[c] = 0;
    end
    for (int k = 0; k < 34; k++) acc[k] = 1 + 5 * k + ((k >= gap_k) ? gap_len : 0);
    dn   = acc[33] + 5;
    last = dn + 2;
    for (int k = 0; k < 34; k++) begin
      st = (k == 0) ? 1 : acc[k-1] + 5;
      for (int c = st; c <= acc[k]; c++) begin
        e_rdy[c] = 1; e_bsy[c] = 1; e_idx[c] = 6'(k); e_ic[c] = 1;
      end
      for (int c = acc[k] + 1; c <= acc[k] + 4; c++) begin
        e_bsy[c] = 1; e_idx[c] = 6'(k); e_ic[c] = 1;
      end
      e_en[acc[k] + 2] = 34'd1 << k;
      e_en[acc[k] + 3] = 34'd1 << k;
      en_end = (k < 33) ? acc[k+1] : last;
      for (int c = acc[k] + 1; c <= en_end; c++) begin
        e_d[c] = 32'hC0DE0000 + 32'(k); e_dv[c] = 1;
      end
    end
    e_dn[dn] = 1; e_bsy[dn] = 1;
    for (int c = dn + 1; c <= last; c++) begin e_ic[c] = 1; e_idx[c] = '0; end

    cur_k = 0; pushed = -1; prev_en = '0;
    for (int c = 0; c <= last; c++) begin
      gap = (gap_len > 0) && (c >= acc[gap_k] - gap_len) && (c < acc[gap_k]);
      io_start = (c == 0) || (c == 50);
      io_abort = 1'b0;
      while (cur_k < 33 && c > acc[cur_k]) cur_k++;
      if (c >= 1 && pushed != cur_k) begin
        sb_q.push_back(32'hC0DE0000 + 32'(cur_k));
        pushed = cur_k;
      end
      io_word_in    = 32'hC0DE0000 + 32'(cur_k);
      io_word_valid = (c >= 1) && (c <= acc[33]) && !gap;

      if (c >= 1) begin
        tests++;
        if (io_configs_en !== e_en[c]) begin
          fails++;
          $display("FAIL %s_en c=%0d got %h exp %h", name, c, io_configs_en, e_en[c]);
        end
        tests++;
        if (io_word_ready !== e_rdy[c] || io_busy !== e_bsy[c] || io_done !== e_dn[c]) begin
          fails++;
          $display("FAIL %s_ctl c=%0d got rdy=%b busy=%b done=%b exp %b %b %b", name, c,
                   io_word_ready, io_busy, io_done, e_rdy[c], e_bsy[c], e_dn[c]);
        end
        if (e_ic[c]) begin
          tests++;
          if (io_word_idx !== e_idx[c]) begin
            fails++;
            $display("FAIL %s_idx c=%0d got %0d exp %0d", name, c, io_word_idx, e_idx[c]);
          end
        end
        if (e_dv[c]) begin
          tests++;
          if (io_d_out !== e_d[c]) begin
            fails++;
            $display("FAIL %s_data c=%0d got %h exp %h", name, c, io_d_out, e_d[c]);
          end
        end
        if (io_configs_en != 0 && prev_en == 0) begin
          tests++;
          if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL %s_sb c=%0d got strobe %h exp none", name, c, io_configs_en);
          end else begin
            exp_w = sb_q.pop_front();
            if (io_d_out !== exp_w || io_configs_en !== (34'd1 << exp_w[5:0])) begin
              fails++;
              $display("FAIL %s_sb c=%0d got d=%h en=%h exp d=%h en=%h", name, c,
                       io_d_out, io_configs_en, exp_w, 34'd1 << exp_w[5:0]);
            end
          end
        end
        prev_en = io_configs_en;
      end
      @(negedge clk);
    end
    io_start = 0; io_word_valid = 0;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL %s_sb_left got %0d exp 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_abort();
    for (int c = 0; c <= 45; c++) begin
      io_start      = (c == 0) || (c == 35) || (c == 38);
      io_abort      = (c == 28) || (c == 36);
      io_word_valid = (c >= 1 && c <= 27) || (c == 36) || (c == 39);
      io_word_in    = (c == 36) ? 32'hDEADBEEF : (c == 39) ? 32'h12345678
                                : 32'hC0DE0000 + 32'((c + 3) / 5);
      reset         = (c == 40);
      if (c == 28) begin
        tests++;
        if (io_configs_en !== (34'd1 << 5) || io_word_idx !== 6'd5) begin
          fails++;
          $display("FAIL abort_pre c=%0d got en=%h idx=%0d exp %h 5", c, io_configs_en,
                   io_word_idx, 34'd1 << 5);
        end
      end
      if (c == 29) begin
        tests++;
        if (io_configs_en !== 0 || io_busy !== 0 || io_word_idx !== 0 ||
            io_word_ready !== 0 || io_done !== 0 || io_d_out !== 32'hC0DE0005) begin
          fails++;
          $display("FAIL abort_next got en=%h busy=%b idx=%0d rdy=%b done=%b d=%h exp 0 0 0 0 0 c0de0005",
                   io_configs_en, io_busy, io_word_idx, io_word_ready, io_done, io_d_out);
        end
      end
      if (c >= 30 && c <= 35) begin
        tests++;
        if (io_done !== 0 || io_busy !== 0 || io_word_ready !== 0) begin
          fails++;
          $display("FAIL abort_idle c=%0d got done=%b busy=%b rdy=%b exp 0 0 0",
                   c, io_done, io_busy, io_word_ready);
        end
      end
      if (c == 36) begin
        tests++;
        if (io_word_ready !== 1 || io_word_idx !== 0 || io_busy !== 1) begin
          fails++;
          $display("FAIL restart got rdy=%b idx=%0d busy=%b exp 1 0 1",
                   io_word_ready, io_word_idx, io_busy);
        end
      end
      if (c == 37) begin
        tests++;
        if (io_d_out !== 32'hC0DE0005 || io_busy !== 0) begin
          fails++;
          $display("FAIL abort_xfer got d=%h busy=%b exp c0de0005 0", io_d_out, io_busy);
        end
      end
      if (c == 40) begin
        tests++;
        if (io_d_out !== 32'h12345678 || io_configs_en !== 0) begin
          fails++;
          $display("FAIL setup_data got d=%h en=%h exp 12345678 0", io_d_out, io_configs_en);
        end
      end
      if (c >= 41) begin
        tests++;
        if (io_d_out !== 0 || io_busy !== 0 || io_configs_en !== 0 || io_word_idx !== 0) begin
          fails++;
          $display("FAIL midload_reset c=%0d got d=%h busy=%b en=%h idx=%0d exp 0 0 0 0",
                   c, io_d_out, io_busy, io_configs_en, io_word_idx);
        end
      end
      @(negedge clk);
    end
    io_start = 0; io_abort = 0; io_word_valid = 0; reset = 0;
  endtask

  task automatic test_start_abort_idle();
    for (int c = 0; c <= 3; c++) begin
      io_start = (c == 0); io_abort = (c == 0); io_word_valid = 1'b1;
      io_word_in = 32'hFEEDF00D;
      if (c >= 1) begin
        tests++;
        if (io_busy !== 0 || io_word_ready !== 0 || io_word_idx !== 0 || io_d_out !== 0) begin
          fails++;
          $display("FAIL start_abort_idle c=%0d got busy=%b rdy=%b idx=%0d d=%h exp 0 0 0 0",
                   c, io_busy, io_word_ready, io_word_idx, io_d_out);
        end
      end
      @(negedge clk);
    end
    io_start = 0; io_abort = 0; io_word_valid = 0;
  endtask

  task automatic test_sweep();
    int k, pushed;
    logic [2:0] e_en;
    logic [31:0] exp_w;
    pushed = -1;
    for (int c = 0; c <= 15; c++) begin
      k = (c + 2) / 4;
      if (k > 2) k = 2;
      sw_start = (c == 0); sw_abort = 0;
      sw_valid = (c >= 1) && (c <= 9);
      sw_word  = 32'hA0 + 32'(k);
      if (c >= 1 && c <= 9 && pushed != k) begin
        sb_q.push_back(32'hA0 + 32'(k));
        pushed = k;
      end
      if (c >= 1) begin
        e_en = (c == 3) ? 3'b001 : (c == 7) ? 3'b010 : (c == 11) ? 3'b100 : 3'b000;
        tests++;
        if (sw_en !== e_en || sw_done !== (c == 13) || sw_busy !== (c <= 13)) begin
          fails++;
          $display("FAIL sweep c=%0d got en=%b done=%b busy=%b exp %b %b %b", c,
                   sw_en, sw_done, sw_busy, e_en, c == 13, c <= 13);
        end
        if (sw_en != 0) begin
          tests++;
          if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL sweep_sb c=%0d got strobe %b exp none", c, sw_en);
          end else begin
            exp_w = sb_q.pop_front();
            if (sw_d_out !== exp_w) begin
              fails++;
              $display("FAIL sweep_sb c=%0d got d=%h exp %h", c, sw_d_out, exp_w);
            end
          end
        end
      end
      @(negedge clk);
    end
    sw_start = 0; sw_valid = 0;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL sweep_sb_left got %0d exp 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    reset = 1'b1;
    io_start = 0; io_abort = 0; io_word_valid = 0; io_word_in = '0;
    sw_start = 0; sw_abort = 0; sw_valid = 0; sw_word = '0;
    test_reset();
    test_start_abort_idle();
    test_load(34, 0, "full");
    test_load(10, 7, "backpr");
    test_abort();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
